// File: rtl/multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : multiword_add_sequencer (with CarrySelectAdder word datapath)
//  Brief    : WORDS*32-bit adder that streams one 32-bit word per cycle,
//             LSW first, through a single 32-bit carry-select adder.
//  Revision : 1.0 - initial release
// ============================================================================

module CarrySelectAdder (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] F,
    output logic        Cout
);
    logic [16:0] w_lo;
    logic [16:0] w_hi0;
    logic [16:0] w_hi1;

    // Upper half is computed for both carry-ins, then picked by the lower carry
    assign w_lo  = {1'b0, A[15:0]}  + {1'b0, B[15:0]}  + {16'd0, Cin};
    assign w_hi0 = {1'b0, A[31:16]} + {1'b0, B[31:16]};
    assign w_hi1 = {1'b0, A[31:16]} + {1'b0, B[31:16]} + 17'd1;

    assign F[15:0]          = w_lo[15:0];
    assign {Cout, F[31:16]} = w_lo[16] ? w_hi1 : w_hi0;
endmodule

module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDS*32-1:0] a,
    input  logic [WORDS*32-1:0] b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDS*32-1:0] sum,
    output logic                cout,
    output logic                ovf
);
    localparam int              W        = WORDS * 32;
    localparam int              IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic [31:0]      w_a_word;
    logic [31:0]      w_b_word;
    logic [31:0]      w_f;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;

    assign w_a_word = r_a[{r_idx, 5'd0} +: 32];
    assign w_b_word = r_b[{r_idx, 5'd0} +: 32];

    CarrySelectAdder u_adder (
        .A    (w_a_word),
        .B    (w_b_word),
        .Cin  (r_carry),
        .F    (w_f),
        .Cout (w_cout)
    );

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == LAST_IDX);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next_state = S_RUN;
            S_RUN:   if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[{r_idx, 5'd0} +: 32] <= w_f;
                    r_carry                    <= w_cout;
                    r_idx                      <= r_idx + 1'b1;
                    // Signed overflow judged on the MSW: equal operand signs, differing result sign
                    if (w_last) begin
                        r_cout <= w_cout;
                        r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_f[31] != r_a[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multiword_add_sequencer
//  Brief    : Randomized self-checking bench for WORDS=4 and WORDS=1 builds
//             against an arithmetic reference (a + b + cin).
//  Revision : 1.0 - initial release
// ============================================================================

module tb_multiword_add_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         iv4, ir4, ci4, ov4, or4, co4, of4;
    logic [127:0] a4, b4, s4;
    logic         iv1, ir1, ci1, ov1, or1, co1, of1;
    logic [31:0]  a1, b1, s1;

    int n_err = 0;
    int n_chk = 0;

    multiword_add_sequencer #(.WORDS(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .cin(ci4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(of4)
    );

    multiword_add_sequencer #(.WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(ci1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1)
    );

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        // Bias toward carry-propagating words
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [127:0] rand128();
        return {rand_word(), rand_word(), rand_word(), rand_word()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op4(input logic [127:0] a, input logic [127:0] b, input logic c,
                       input int stall, input bit busy);
        logic [128:0] full;
        logic         exp_ovf;
        int           n;
        full    = {1'b0, a} + {1'b0, b} + 129'(c);
        exp_ovf = (a[127] == b[127]) && (full[127] != a[127]);
        iv4 = 1'b1; a4 = a; b4 = b; ci4 = c; or4 = (stall == 0);
        n = 0;
        while (!ir4 && n < 100) begin tick(); n++; end
        check_val("w4_in_ready_idle", ir4, 1);
        tick();
        if (busy) begin a4 = rand128(); b4 = rand128(); ci4 = ~c; end
        else iv4 = 1'b0;
        check_val("w4_in_ready_run", ir4, 0);
        n = 0;
        while (!ov4 && n < 100) begin
            tick(); n++;
            if (busy) a4 = rand128();
        end
        check_val("w4_latency", n, 4);
        check_val("w4_sum", s4, full[127:0]);
        check_val("w4_cout", co4, full[128]);
        check_val("w4_ovf", of4, exp_ovf);
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                tick();
                check_val("w4_hold_sum", {of4, co4, s4}, {exp_ovf, full});
                check_val("w4_hold_flags", {ov4, ir4}, 2'b10);
            end
            or4 = 1'b1;
        end
        tick();
        check_val("w4_after_handshake", {ov4, ir4}, 2'b01);
        iv4 = 1'b0;
    endtask

    task automatic op1(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] full;
        logic        exp_ovf;
        int          n;
        full    = {1'b0, a} + {1'b0, b} + 33'(c);
        exp_ovf = (a[31] == b[31]) && (full[31] != a[31]);
        iv1 = 1'b1; a1 = a; b1 = b; ci1 = c; or1 = 1'b1;
        check_val("w1_in_ready", ir1, 1);
        tick();
        iv1 = 1'b0;
        n = 0;
        while (!ov1 && n < 20) begin tick(); n++; end
        check_val("w1_latency", n, 1);
        check_val("w1_result", {of1, co1, s1}, {exp_ovf, full});
        tick();
        check_val("w1_idle", {ov1, ir1}, 2'b01);
    endtask

    initial begin
        rst = 1'b1;
        iv4 = 0; a4 = '0; b4 = '0; ci4 = 0; or4 = 0;
        iv1 = 0; a1 = '0; b1 = '0; ci1 = 0; or1 = 0;
        repeat (3) tick();
        check_val("rst_in_ready_low", {ir4, ir1}, 2'b00);
        rst = 1'b0;
        #1;
        check_val("rst_state4", {ov4, co4, of4, s4}, '0);
        check_val("rst_in_ready", {ir4, ir1, ov1}, 3'b110);

        op4('1, '0, 1'b1, 0, 0);
        op4({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 0, 0);
        op4({1'b1, 127'd0}, {1'b1, 127'd0}, 1'b0, 0, 0);
        op4(rand128(), rand128(), 1'($urandom), 10, 0);
        op4(rand128(), rand128(), 1'($urandom), 0, 1);
        op4(rand128(), rand128(), 1'($urandom), 3, 1);

        // Reset on the second RUN cycle
        iv4 = 1'b1; a4 = rand128(); b4 = rand128(); ci4 = 1'b1; or4 = 1'b1;
        check_val("mid_rst_in_ready", ir4, 1);
        tick();
        iv4 = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_val("mid_rst_in_ready_low", ir4, 0);
        tick();
        rst = 1'b0;
        #1;
        check_val("mid_rst_state", {ov4, co4, of4, s4}, '0);
        check_val("mid_rst_in_ready", ir4, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("mid_rst_no_output", ov4, 0);
        end
        op4(128'd5, 128'd7, 1'b0, 0, 0);

        for (int i = 0; i < 30; i++)
            op4(rand128(), rand128(), 1'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        op1(32'hFFFF_FFFF, 32'd1, 1'b0);
        for (int i = 0; i < 1000; i++)
            op1(rand_word(), rand_word(), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
